// File: rtl/cpu_control_unit.sv
// Two-state fetch/execute sequencer: owns the PC and IR, fetches over a busy-wait
// handshake and decodes IR into reg_file addresses, write enable and ALU/mux controls.
module cpu_control_unit #(
    parameter logic [31:0] PC_RESET     = 32'h0000_0000,
    parameter int unsigned OFFSET_SHIFT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] PC,
    output logic        IMEM_READ,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] INSTRUCTION,
    input  logic        ZERO,
    output logic [2:0]  INADDRESS,
    output logic [2:0]  OUT1ADDRESS,
    output logic [2:0]  OUT2ADDRESS,
    output logic        WRITE,
    output logic [7:0]  IMMEDIATE,
    output logic        IMM_SEL,
    output logic        SUB_SEL,
    output logic [2:0]  ALUOP,
    output logic        ILLEGAL
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  op;
    logic        take_branch;
    logic        unused_ir_bits;

    // Offset is a signed byte scaled to a word offset; arithmetic wraps mod 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                            input logic [7:0]  offset,
                                            input logic        taken);
        logic signed [31:0] ext;
        ext = {{24{offset[7]}}, offset};
        if (taken)
            return pc + 32'd4 + 32'(ext <<< OFFSET_SHIFT);
        return pc + 32'd4;
    endfunction

    assign op             = ir_q[31:24];
    assign take_branch    = (op == OP_J) || ((op == OP_BEQ) && ZERO);
    assign unused_ir_bits = ^{ir_q[23:19], ir_q[15:11], ir_q[7:3]};

    assign PC          = pc_q;
    assign INADDRESS   = ir_q[18:16];
    assign OUT1ADDRESS = ir_q[10:8];
    assign OUT2ADDRESS = ir_q[2:0];
    assign IMMEDIATE   = ir_q[7:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH: begin
                if (!IMEM_BUSYWAIT) begin
                    ir_d    = INSTRUCTION;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                pc_d    = next_pc(pc_q, ir_q[23:16], take_branch);
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Controls are only live during EXEC and are forced low while RESET is held.
    always_comb begin
        IMEM_READ = 1'b0;
        WRITE     = 1'b0;
        IMM_SEL   = 1'b0;
        SUB_SEL   = 1'b0;
        ALUOP     = ALU_FWD;
        ILLEGAL   = 1'b0;
        if (!RESET) begin
            if (state_q == FETCH) begin
                IMEM_READ = 1'b1;
            end else begin
                case (op)
                    OP_LOADI: begin IMM_SEL = 1'b1; WRITE = 1'b1; end
                    OP_MOV:   WRITE = 1'b1;
                    OP_ADD:   begin ALUOP = ALU_ADD; WRITE = 1'b1; end
                    OP_SUB:   begin ALUOP = ALU_ADD; SUB_SEL = 1'b1; WRITE = 1'b1; end
                    OP_AND:   begin ALUOP = ALU_AND; WRITE = 1'b1; end
                    OP_OR:    begin ALUOP = ALU_OR;  WRITE = 1'b1; end
                    OP_J:     ;
                    OP_BEQ:   begin ALUOP = ALU_ADD; SUB_SEL = 1'b1; end
                    default:  ILLEGAL = 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboarded bench for cpu_control_unit: expected decode/PC results are queued when an
// instruction is presented and popped when the unit sits in EXEC.
module tb_cpu_control_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] PC;
    logic        IMEM_READ;
    logic        IMEM_BUSYWAIT;
    logic [31:0] INSTRUCTION;
    logic        ZERO;
    logic [2:0]  INADDRESS, OUT1ADDRESS, OUT2ADDRESS;
    logic        WRITE;
    logic [7:0]  IMMEDIATE;
    logic        IMM_SEL, SUB_SEL;
    logic [2:0]  ALUOP;
    logic        ILLEGAL;

    typedef struct {
        logic [2:0]  inaddr;
        logic [2:0]  out1;
        logic [2:0]  out2;
        logic [7:0]  imm;
        logic        wr;
        logic        isel;
        logic        ssel;
        logic        ill;
        logic [2:0]  alu;
        logic [31:0] npc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pc;

    cpu_control_unit dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .IMEM_READ(IMEM_READ),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
        .INADDRESS(INADDRESS), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .WRITE(WRITE), .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL), .SUB_SEL(SUB_SEL),
        .ALUOP(ALUOP), .ILLEGAL(ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc,
                                   input logic zero);
        exp_t        e;
        logic        taken;
        logic [31:0] off;
        e.inaddr = instr[18:16];
        e.out1   = instr[10:8];
        e.out2   = instr[2:0];
        e.imm    = instr[7:0];
        e.wr = 0; e.isel = 0; e.ssel = 0; e.ill = 0; e.alu = 3'b000;
        taken = 0;
        case (instr[31:24])
            8'h00: begin e.isel = 1; e.wr = 1; end
            8'h01: e.wr = 1;
            8'h02: begin e.alu = 3'b001; e.wr = 1; end
            8'h03: begin e.alu = 3'b001; e.ssel = 1; e.wr = 1; end
            8'h04: begin e.alu = 3'b010; e.wr = 1; end
            8'h05: begin e.alu = 3'b011; e.wr = 1; end
            8'h06: taken = 1;
            8'h07: begin e.alu = 3'b001; e.ssel = 1; taken = zero; end
            default: e.ill = 1;
        endcase
        off   = {{22{instr[23]}}, instr[23:16], 2'b00};
        e.npc = pc + 32'd4 + (taken ? off : 32'd0);
        return e;
    endfunction

    task automatic check_exec(output exp_t e);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            e = model(32'hFF00_0000, exp_pc, 1'b0);
        end else begin
            e = sb_q.pop_front();
        end
        chk("exec_imem_read", {31'd0, IMEM_READ}, 32'd0);
        chk("exec_pc_hold",   PC,                 exp_pc);
        chk("inaddress",      {29'd0, INADDRESS},   {29'd0, e.inaddr});
        chk("out1address",    {29'd0, OUT1ADDRESS}, {29'd0, e.out1});
        chk("out2address",    {29'd0, OUT2ADDRESS}, {29'd0, e.out2});
        chk("immediate",      {24'd0, IMMEDIATE},   {24'd0, e.imm});
        chk("write",          {31'd0, WRITE},       {31'd0, e.wr});
        chk("imm_sel",        {31'd0, IMM_SEL},     {31'd0, e.isel});
        chk("sub_sel",        {31'd0, SUB_SEL},     {31'd0, e.ssel});
        chk("aluop",          {29'd0, ALUOP},       {29'd0, e.alu});
        chk("illegal",        {31'd0, ILLEGAL},     {31'd0, e.ill});
    endtask

    // Enters in FETCH about 1 time unit after an edge; leaves in the next FETCH.
    task automatic run_instr(input logic [31:0] instr, input logic zero, input int waits);
        exp_t e;
        chk("fetch_imem_read", {31'd0, IMEM_READ}, 32'd1);
        chk("fetch_pc",        PC,                 exp_pc);
        chk("fetch_write",     {31'd0, WRITE},     32'd0);
        IMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < waits; i++) begin
            @(posedge CLK); #1;
            chk("stall_imem_read", {31'd0, IMEM_READ}, 32'd1);
            chk("stall_pc",        PC,                 exp_pc);
        end
        INSTRUCTION   = instr;
        ZERO          = zero;
        IMEM_BUSYWAIT = 1'b0;
        sb_q.push_back(model(instr, exp_pc, zero));
        @(posedge CLK); #1;
        IMEM_BUSYWAIT = 1'b1;
        check_exec(e);
        @(posedge CLK); #1;
        exp_pc = e.npc;
        chk("next_pc",        PC,                   exp_pc);
        chk("post_write",     {31'd0, WRITE},       32'd0);
        chk("post_inaddress", {29'd0, INADDRESS},   {29'd0, e.inaddr});
    endtask

    initial begin
        exp_t e;
        RESET = 1'b0; IMEM_BUSYWAIT = 1'b1; INSTRUCTION = 32'h0; ZERO = 1'b0;
        #5 RESET = 1'b1;
        #2;
        chk("rst_pc",        PC,                 32'h0);
        chk("rst_imem_read", {31'd0, IMEM_READ}, 32'd0);
        chk("rst_write",     {31'd0, WRITE},     32'd0);
        chk("rst_illegal",   {31'd0, ILLEGAL},   32'd0);
        chk("rst_aluop",     {29'd0, ALUOP},     32'd0);
        chk("rst_imm_sel",   {31'd0, IMM_SEL},   32'd0);
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b0;
        #1;
        exp_pc = 32'h0;

        run_instr(32'h0002_002A, 1'b0, 0);   // loadi r2,42
        run_instr(32'h0301_0203, 1'b0, 0);   // sub r1,r2,r3
        run_instr(32'h07FE_0000, 1'b1, 0);   // beq -8 taken: 8 -> 4
        run_instr(32'h0103_0100, 1'b0, 0);   // mov r3,r1
        run_instr(32'h07FE_0000, 1'b0, 0);   // beq not taken: 8 -> 12
        run_instr(32'h0405_0607, 1'b0, 3);   // and with 3 wait states
        run_instr(32'h0506_0102, 1'b0, 1);   // or
        run_instr(32'h0602_0000, 1'b0, 0);   // j +8: 20 -> 32
        run_instr(32'hFF00_0000, 1'b0, 0);   // undefined opcode

        // Reset asserted in the middle of EXEC of an add.
        chk("pre_add_pc", PC, exp_pc);
        INSTRUCTION   = 32'h0207_0102;
        IMEM_BUSYWAIT = 1'b0;
        sb_q.push_back(model(32'h0207_0102, exp_pc, 1'b0));
        @(posedge CLK); #1;
        IMEM_BUSYWAIT = 1'b1;
        check_exec(e);
        #2 RESET = 1'b1;
        #1;
        chk("midrst_write",     {31'd0, WRITE},     32'd0);
        chk("midrst_pc",        PC,                 32'h0);
        chk("midrst_imem_read", {31'd0, IMEM_READ}, 32'd0);
        chk("midrst_inaddress", {29'd0, INADDRESS}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        #1;
        exp_pc = 32'h0;

        run_instr(32'h0004_0011, 1'b0, 0);   // loadi r4,0x11 from PC_RESET
        run_instr(32'h0680_0000, 1'b0, 0);   // j -512: 4 -> wraps to 0xFFFFFE08
        run_instr(32'h0201_0203, 1'b0, 2);   // add at the wrapped address

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
